// File: rtl/phj_pkg.sv
// rtl/phj_pkg.sv - shared tuple and drain-state types for the partitioning stage
package phj_pkg;

    localparam int TUPLE_DATA_W = 64;

    typedef struct packed {
        logic [TUPLE_DATA_W-1:0] data;
        logic [31:0]             tag;
        logic [63:0]             serialnum;
        logic                    was_joined;
    } tuple_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/tuple_fifo.sv
// rtl/tuple_fifo.sv - synchronous FWFT queue; head is read as zero while empty
module tuple_fifo #(
    parameter int WIDTH = 161,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign cnt   = r_cnt;
    assign full  = (r_cnt == CW'(DEPTH));
    assign empty = (r_cnt == '0);
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/tuple_splitter.sv
// rtl/tuple_splitter.sv - routes tuples to one of two queued outputs by a tag bit
module tuple_splitter
    import phj_pkg::*;
#(
    parameter int INPUT_SIZE   = 64,
    parameter int DECISION_BIT = 0,
    parameter int DEPTH        = 4
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INPUT_SIZE-1:0]       in_data,
    input  logic [31:0]                 in_tag,
    input  logic [63:0]                 in_serialnum,
    input  logic                        in_was_joined,
    input  logic                        in_last_processed,
    input  logic [1:0]                  out_ready,
    output logic [1:0]                  out_valid,
    output logic [1:0][INPUT_SIZE-1:0]  out_data,
    output logic [1:0][31:0]            out_tag,
    output logic [1:0][63:0]            out_serialnum,
    output logic [1:0]                  out_was_joined,
    output logic [1:0]                  out_last_processed
);
    localparam int W  = INPUT_SIZE + 32 + 64 + 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 w_sel;
    logic                 w_in_ready;
    logic [1:0]           w_push;
    logic [1:0]           w_pop;
    logic [1:0]           w_full;
    logic [1:0]           w_empty;
    logic [1:0]           w_out_valid;
    logic [1:0]           w_pend;
    logic [1:0]           w_eos;
    logic [W-1:0]         w_din;
    logic [W-1:0]         w_dout [2];
    logic [CW-1:0]        w_cnt  [2];
    drain_state_t         r_state     [2];
    drain_state_t         w_state_nxt [2];

    assign w_sel      = in_tag[DECISION_BIT];
    assign w_din      = {in_data, in_tag, in_serialnum, in_was_joined};
    // Outputs are gated by resetn so the interface reads idle during the reset cycle itself.
    assign w_in_ready = resetn & ~(|w_pend) & ~w_full[w_sel];
    assign in_ready   = w_in_ready;

    for (genvar k = 0; k < 2; k++) begin : g_q
        assign w_push[k]      = in_valid & w_in_ready & (w_sel == 1'(k));
        assign w_out_valid[k] = resetn & ~w_empty[k];
        assign w_pop[k]       = w_out_valid[k] & out_ready[k];

        tuple_fifo #(
            .WIDTH (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk    (clk),
            .resetn (resetn),
            .push   (w_push[k]),
            .pop    (w_pop[k]),
            .din    (w_din),
            .dout   (w_dout[k]),
            .cnt    (w_cnt[k]),
            .full   (w_full[k]),
            .empty  (w_empty[k])
        );

        assign out_valid[k]          = w_out_valid[k];
        assign out_data[k]           = resetn ? w_dout[k][W-1 -: INPUT_SIZE] : '0;
        assign out_tag[k]            = resetn ? w_dout[k][96:65]             : '0;
        assign out_serialnum[k]      = resetn ? w_dout[k][64:1]              : '0;
        assign out_was_joined[k]     = resetn & w_dout[k][0];
        assign out_last_processed[k] = w_eos[k];
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                r_state[k] <= RUN;
            end else begin
                r_state[k] <= w_state_nxt[k];
            end
        end
    end

    // Both outputs enter DRAIN together; each leaves once its own queue is empty.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_state_nxt[k] = r_state[k];
            case (r_state[k])
                RUN:     if (in_last_processed && !(|w_pend)) w_state_nxt[k] = DRAIN;
                DRAIN:   if (w_empty[k] && !w_push[k])        w_state_nxt[k] = RUN;
                default: w_state_nxt[k] = RUN;
            endcase
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_pend[k] = 1'b0;
            w_eos[k]  = 1'b0;
            w_pend[k] = (r_state[k] == DRAIN);
            w_eos[k]  = resetn & (r_state[k] == DRAIN) & w_empty[k] & ~w_push[k];
        end
    end

endmodule
